// File: rtl/fnd_scan_controller.sv
// 4-digit 7-segment scan controller: guard/show slot timing, once-per-frame
// snapshot of display data, leading-zero suppression and per-digit masking.
module fnd_scan_controller #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_mask,
  input  logic        i_lz_en,
  input  logic        i_page,
  output logic [2:0]  o_digitSelect,
  output logic        o_blank,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    dp_q, dp_d;
  logic [3:0]    mask_q, mask_d;
  logic          lz_q, lz_d;
  logic          page_q, page_d;
  logic          capture;
  logic          tick_d, blank_d, dp_out_d;
  logic [3:0]    bcd_d;
  logic [2:0]    dsel_d;

  // True when every nibble at or above digit d is zero; digit 0 always shows.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
    case (d)
      2'd1:    lz_blank = (v[15:4] == 12'h000);
      2'd2:    lz_blank = (v[15:8] == 8'h00);
      2'd3:    lz_blank = (v[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    capture = 1'b0;
    tick_d  = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          capture = 1'b1;
          tick_d  = 1'b1;
          state_d = ST_GUARD;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            state_d = ST_GUARD;
            if (digit_q == 2'd3) begin
              capture = 1'b1;
              tick_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end

    val_d  = capture ? i_value : val_q;
    dp_d   = capture ? i_dp    : dp_q;
    mask_d = capture ? i_mask  : mask_q;
    lz_d   = capture ? i_lz_en : lz_q;
    page_d = capture ? i_page  : page_q;

    // Outputs are precomputed from next state so they register on the same edge.
    blank_d  = (state_d != ST_SHOW) | mask_d[digit_d] | (lz_d & lz_blank(val_d, digit_d));
    bcd_d    = (state_d == ST_IDLE) ? 4'h0 : val_d[{digit_d, 2'b00} +: 4];
    dp_out_d = (state_d == ST_IDLE) ? 1'b0 : dp_d[digit_d];
    dsel_d   = (state_d == ST_IDLE) ? 3'b000 : {page_d, digit_d};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      digit_q       <= 2'd0;
      // NOTE: shadow registers are small and reset explicitly so a fresh frame never shows stale data.
      val_q         <= 16'h0000;
      dp_q          <= 4'h0;
      mask_q        <= 4'h0;
      lz_q          <= 1'b0;
      page_q        <= 1'b0;
      o_digitSelect <= 3'b000;
      o_blank       <= 1'b1;
      o_bcd         <= 4'h0;
      o_dp          <= 1'b0;
      o_frame_tick  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      val_q         <= val_d;
      dp_q          <= dp_d;
      mask_q        <= mask_d;
      lz_q          <= lz_d;
      page_q        <= page_d;
      o_digitSelect <= dsel_d;
      o_blank       <= blank_d;
      o_bcd         <= bcd_d;
      o_dp          <= dp_out_d;
      o_frame_tick  <= tick_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: a time-based frame/slot model predicts every
// output each cycle under directed and randomized stimulus.
module tb_fnd_scan_controller;

  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp, mask;
  logic        lz_en, page;
  logic [2:0]  o_digitSelect;
  logic        o_blank, o_dp, o_frame_tick;
  logic [3:0]  o_bcd;

  fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_value(value), .i_dp(dp),
    .i_mask(mask), .i_lz_en(lz_en), .i_page(page),
    .o_digitSelect(o_digitSelect), .o_blank(o_blank), .o_bcd(o_bcd),
    .o_dp(o_dp), .o_frame_tick(o_frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: time since enable t, frame snapshot taken every 4*SD cycles.
  bit          run = 0;
  int          t = 0;
  bit          exp_tick = 0;
  logic [15:0] s_val = 0;
  logic [3:0]  s_dp = 0, s_mask = 0;
  logic        s_lz = 0, s_page = 0;

  task automatic snap();
    s_val = value; s_dp = dp; s_mask = mask; s_lz = lz_en; s_page = page;
  endtask

  task automatic step_model();
    exp_tick = 0;
    if (!rst_n) begin
      run = 0; t = 0;
      s_val = 0; s_dp = 0; s_mask = 0; s_lz = 0; s_page = 0;
    end else if (!en) begin
      run = 0; t = 0;
    end else if (!run) begin
      run = 1; t = 0; snap(); exp_tick = 1;
    end else begin
      t++;
      if (t == 4 * SD) begin
        t = 0; snap(); exp_tick = 1;
      end
    end
  endtask

  function automatic int cur_digit();
    return (t / SD) % 4;
  endfunction

  function automatic bit in_show();
    return run && ((t % SD) >= BL);
  endfunction

  function automatic logic exp_blank();
    int d;
    d = cur_digit();
    if (!in_show()) return 1'b1;
    if (s_mask[d]) return 1'b1;
    if (s_lz && d > 0 && ((s_val >> (4 * d)) == 16'h0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    int d;
    d = cur_digit();
    check("tick", o_frame_tick, exp_tick);
    check("blank", o_blank, exp_blank());
    check("dsel", o_digitSelect, run ? {s_page, d[1:0]} : 3'b000);
    if (run) begin
      check("bcd", o_bcd, (s_val >> (4 * d)) & 16'hF);
      check("dp", o_dp, s_dp[d]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model();
    #1;
    check_outputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model is in SHOW of digit want_d; bounded.
  task automatic wait_show_digit(input int want_d);
    int k;
    k = 0;
    while (!(in_show() && cur_digit() == want_d) && k < 100) begin
      cycle();
      k++;
    end
    if (k >= 100) check("wait_timeout", 16'd1, 16'd0);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    int n;
    rst_n = 0; en = 1; value = 16'h1234; dp = 0; mask = 0; lz_en = 0; page = 0;
    #12;
    check("rst_blank", o_blank, 1'b1);
    check("rst_dsel", o_digitSelect, 3'b000);
    check("rst_bcd", o_bcd, 4'h0);
    check("rst_dp", o_dp, 1'b0);
    check("rst_tick", o_frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // Basic scan of 1234 and frame period.
    cycle();
    check("first_tick", o_frame_tick, 1'b1);
    check("first_bcd", o_bcd, 4'h4);
    n = 0;
    do begin cycle(); n++; end while (!o_frame_tick && n < 100);
    check("tick_period", 16'(n), 16'd32);

    // Mid-frame change is held off until the next snapshot.
    run_cycles(10);
    value = 16'h5678;
    n = 0;
    do begin cycle(); n++; end while (!o_frame_tick && n < 100);
    check("new_frame_bcd", o_bcd, 4'h8);
    run_cycles(40);

    // Leading-zero suppression.
    lz_en = 1; value = 16'h0070;
    run_cycles(70);
    value = 16'h0000;
    run_cycles(70);

    // Mask, decimal point, page.
    lz_en = 0; value = 16'h4321; mask = 4'b0101; dp = 4'b0010; page = 1;
    run_cycles(70);
    check("page_bit", o_digitSelect[2], 1'b1);

    // Disable during SHOW of digit 2, then re-enable.
    mask = 0;
    wait_show_digit(2);
    en = 0;
    cycle();
    check("dis_blank", o_blank, 1'b1);
    check("dis_dsel", o_digitSelect, 3'b000);
    run_cycles(3);
    en = 1;
    cycle();
    check("reen_tick", o_frame_tick, 1'b1);
    run_cycles(40);

    // Asynchronous reset mid-SHOW.
    wait_show_digit(1);
    #2;
    rst_n = 0;
    #1;
    check("arst_blank", o_blank, 1'b1);
    check("arst_bcd", o_bcd, 4'h0);
    check("arst_tick", o_frame_tick, 1'b0);
    cycle();
    @(negedge clk);
    rst_n = 1;
    run_cycles(40);

    // Randomized traffic, including disable bursts and wrap collisions.
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if ($urandom_range(0, 19) == 0) value = rand_value();
      if ($urandom_range(0, 29) == 0) begin
        dp = 4'($urandom); mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        lz_en = 1'($urandom); page = 1'($urandom);
      end
      if (en && $urandom_range(0, 149) == 0) en = 0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1;
      if (run && t == 4 * SD - 2 && $urandom_range(0, 3) == 0) en = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
